// File: rtl/mac_arb_pkg.sv
// -----------------------------------------------------------------------------
// mac_arb_pkg
// Shared definitions for the MAC transmit arbiter:
//   - arb_state_e        : arbiter FSM states (IDLE, XFER, IFG)
//   - NUM_Q              : number of transmit queues feeding the arbiter
//   - GRANT_NONE         : grant_id value reported when no queue owns the MAC
//   - IFG_CYCLES_DEFAULT : default inter-frame gap length in clk125 cycles
//   - rr_next()          : round-robin pointer successor (winner + 1 mod NUM_Q)
// -----------------------------------------------------------------------------
package mac_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_IFG  = 2'd2
    } arb_state_e;

    localparam int         NUM_Q              = 3;
    localparam logic [1:0] GRANT_NONE         = 2'd3;
    localparam int         IFG_CYCLES_DEFAULT = 12;

    // Next search start after a grant: the queue just after the winner.
    function automatic logic [1:0] rr_next(input logic [1:0] winner);
        return (winner == 2'd2) ? 2'd0 : winner + 2'd1;
    endfunction

endpackage

// File: rtl/mac_arb_pick.sv
// -----------------------------------------------------------------------------
// mac_arb_pick
// Purely combinational winner selection. The request vector is searched
// starting at i_rr_ptr and wrapping around; the first requesting queue wins.
// A start of 0 gives fixed priority queue 0 > 1 > 2.
//
// Ports:
//   i_req     [NUM_Q-1:0]  queue request vector (bit i = queue i has a frame)
//   i_rr_ptr  [1:0]        queue index at which the search starts (0..2)
//   o_winner  [1:0]        index of the selected queue (0 when none found)
//   o_found                at least one request is present
// -----------------------------------------------------------------------------
module mac_arb_pick
    import mac_arb_pkg::*;
(
    input  logic [NUM_Q-1:0] i_req,
    input  logic [1:0]       i_rr_ptr,
    output logic [1:0]       o_winner,
    output logic             o_found
);

    logic [2:0] w_sum;
    logic [1:0] w_idx;

    // NOTE: every signal written in always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        o_winner = 2'd0;
        o_found  = 1'b0;
        w_sum    = 3'd0;
        w_idx    = 2'd0;
        for (int k = 0; k < NUM_Q; k++) begin
            // Candidate index = (start + k) mod NUM_Q without a divider.
            w_sum = {1'b0, i_rr_ptr} + k[2:0];
            if (w_sum >= 3'd3) begin
                w_sum = w_sum - 3'd3;
            end
            w_idx = w_sum[1:0];
            if (!o_found && i_req[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mac_tx_arbiter
// Arbitrates three first-word-fall-through frame queues onto one MAC transmit
// byte stream. A queue that holds a complete frame is granted in IDLE, its
// bytes are streamed through a registered output stage with valid/ready
// handshaking until its last byte is accepted, then an inter-frame gap of
// IFG_CYCLES idle cycles is enforced before the next arbitration.
//
// Build option:
//   MAC_TX_ARB_STRICT_PRIO_EN  defined   -> strict priority queue 0 > 1 > 2
//                              undefined -> round-robin (default)
//
// Parameters:
//   IFG_CYCLES  idle cycles spent in IFG between frames (0 means one cycle)
//   DATA_W      byte-lane width
//
// Ports:
//   clk125       in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   q_frame_rdy  in   [3]        queue i holds at least one complete frame
//   q_data       in   [3*DATA_W] FWFT head word, queue i at [i*DATA_W +: DATA_W]
//   q_eof        in   [3]        head word of queue i is the last frame byte
//   q_rd         out  [3]        one-hot pop strobe to the granted queue
//   tx_data      out  [DATA_W]   registered byte to the MAC
//   tx_valid     out             tx_data is valid
//   tx_eof       out             tx_data is the last byte of the frame
//   tx_ready     in              MAC accepts the byte when tx_valid && tx_ready
//   grant_id     out  [2]        current owner 0..2, 3 when no owner
//   busy         out             FSM is not in IDLE
// -----------------------------------------------------------------------------
module mac_tx_arbiter
    import mac_arb_pkg::*;
#(
    parameter int IFG_CYCLES = IFG_CYCLES_DEFAULT,
    parameter int DATA_W     = 8
) (
    input  logic                    clk125,
    input  logic                    reset,
    input  logic [NUM_Q-1:0]        q_frame_rdy,
    input  logic [NUM_Q*DATA_W-1:0] q_data,
    input  logic [NUM_Q-1:0]        q_eof,
    output logic [NUM_Q-1:0]        q_rd,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_valid,
    output logic                    tx_eof,
    input  logic                    tx_ready,
    output logic [1:0]              grant_id,
    output logic                    busy
);

    // Gap counter only needs to reach IFG_CYCLES-1; IFG_CYCLES of 0 still
    // spends one cycle in IFG, so its terminal count is also 0.
    localparam int               CNT_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] IFG_LAST = (IFG_CYCLES == 0) ? '0 : CNT_W'(IFG_CYCLES - 1);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [1:0]        r_grant;
    logic              r_eof_popped;
    logic [CNT_W-1:0]  r_ifg_cnt;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_tx_eof;

    logic              w_take_grant;
    logic              w_pop;
    logic              w_accept;
    logic              w_frame_done;
    logic              w_ifg_done;
    logic [1:0]        w_winner;
    logic              w_found;
    logic [1:0]        w_pick_base;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_eof;
    logic [NUM_Q-1:0]  w_grant_onehot;

    // -------------------------------------------------------------------------
    // Arbitration policy
    // -------------------------------------------------------------------------
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
    // Strict priority is the rotating search pinned to start at queue 0.
    assign w_pick_base = 2'd0;
`else
    logic [1:0] r_rr_ptr;

    assign w_pick_base = r_rr_ptr;

    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_take_grant) begin
            r_rr_ptr <= rr_next(w_winner);
        end
    end
`endif

    mac_arb_pick u_pick (
        .i_req    (q_frame_rdy),
        .i_rr_ptr (w_pick_base),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // -------------------------------------------------------------------------
    // Head word of the granted queue
    // -------------------------------------------------------------------------
    always_comb begin
        w_sel_data     = '0;
        w_sel_eof      = 1'b0;
        w_grant_onehot = '0;
        case (r_grant)
            2'd0: begin
                w_sel_data        = q_data[0*DATA_W +: DATA_W];
                w_sel_eof         = q_eof[0];
                w_grant_onehot[0] = 1'b1;
            end
            2'd1: begin
                w_sel_data        = q_data[1*DATA_W +: DATA_W];
                w_sel_eof         = q_eof[1];
                w_grant_onehot[1] = 1'b1;
            end
            2'd2: begin
                w_sel_data        = q_data[2*DATA_W +: DATA_W];
                w_sel_eof         = q_eof[2];
                w_grant_onehot[2] = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control strobes
    // -------------------------------------------------------------------------
    assign w_accept = r_tx_valid && tx_ready;

    always_comb begin
        w_next_state = r_state;
        w_take_grant = 1'b0;
        w_pop        = 1'b0;
        w_frame_done = 1'b0;
        w_ifg_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The grant cycle only records the owner; popping starts in XFER.
                if (w_found) begin
                    w_take_grant = 1'b1;
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                // Refill the output stage when it is empty or being drained,
                // but never read past the frame's last byte.
                w_pop = !r_eof_popped && (!r_tx_valid || tx_ready);
                if (w_accept && r_tx_eof) begin
                    w_frame_done = 1'b1;
                    w_next_state = ST_IFG;
                end
            end
            ST_IFG: begin
                if (r_ifg_cnt == IFG_LAST) begin
                    w_ifg_done   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Ownership, end-of-frame tracking and gap counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            r_grant      <= GRANT_NONE;
            r_eof_popped <= 1'b0;
            r_ifg_cnt    <= '0;
        end else begin
            // The owner keeps the grant until its last byte is accepted, even
            // if its q_frame_rdy drops in the middle of the frame.
            if (w_take_grant) begin
                r_grant <= w_winner;
            end else if (w_frame_done) begin
                r_grant <= GRANT_NONE;
            end

            if (w_pop && w_sel_eof) begin
                r_eof_popped <= 1'b1;
            end else if (w_frame_done) begin
                r_eof_popped <= 1'b0;
            end

            if (r_state == ST_IFG) begin
                r_ifg_cnt <= w_ifg_done ? '0 : r_ifg_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered output stage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_eof   <= 1'b0;
        end else if (w_pop) begin
            r_tx_data  <= w_sel_data;
            r_tx_valid <= 1'b1;
            r_tx_eof   <= w_sel_eof;
        end else if (w_accept) begin
            // Accepted with nothing behind it: the stage empties.
            r_tx_valid <= 1'b0;
            r_tx_eof   <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q_rd     = w_pop ? w_grant_onehot : '0;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_eof   = r_tx_eof;
    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mac_tx_arbiter
// Drives three modelled FWFT frame queues into mac_tx_arbiter. Each batch of
// frames is loaded at once; a frame-level reference model predicts the full
// byte stream (owner, data, eof) and pushes it into a scoreboard queue. A
// monitor pops and compares on every accepted beat and also checks the
// inter-frame gap, hold-while-stalled behaviour and q_rd ownership.
// -----------------------------------------------------------------------------
module tb_mac_tx_arbiter;

    localparam int IFG   = 12;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [1:0] gid;
        logic       eof;
        logic [7:0] data;
    } beat_t;

    logic        clk125;
    logic        reset;
    logic [2:0]  q_frame_rdy;
    logic [23:0] q_data;
    logic [2:0]  q_eof;
    logic [2:0]  q_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_eof;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    // Queue models: circular byte stores, bit 8 = eof.
    logic [8:0] mem [3][DEPTH];
    int         head [3];
    int         tail [3];
    int         frames [3];
    logic [2:0] rdy_mask;

    beat_t exp_q[$];
    int    exp_bytes [3];
    int    rd_cnt [3];
    int    m_ptr;
    int    acc_cnt;
    int    n_tests;
    int    n_fail;

    bit         rdy_rand;
    bit         gap_armed;
    int         gap_cnt;
    bit         hold_pend;
    logic [7:0] hold_data;
    logic       hold_eof;

    mac_tx_arbiter #(.IFG_CYCLES(IFG), .DATA_W(8)) dut (
        .clk125      (clk125),
        .reset       (reset),
        .q_frame_rdy (q_frame_rdy),
        .q_data      (q_data),
        .q_eof       (q_eof),
        .q_rd        (q_rd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_eof      (tx_eof),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_q
        assign q_data[g*8 +: 8] = mem[g][head[g]][7:0];
        assign q_eof[g]         = mem[g][head[g]][8];
        assign q_frame_rdy[g]   = (frames[g] > 0) && rdy_mask[g];
    end

    initial clk125 = 1'b0;
    always #4 clk125 = ~clk125;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_frame(input int qi, input int len, input logic [7:0] base, input bit rnd);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : base + 8'(k);
            mem[qi][tail[qi]] = {(k == len - 1), b};
            tail[qi] = (tail[qi] + 1) % DEPTH;
        end
        frames[qi]++;
    endtask

    // Frame-level reference: repeatedly pick the first queue holding a frame,
    // searching from the round-robin pointer (or from queue 0 under strict
    // priority), and emit that whole frame as expected beats.
    task automatic model_run();
        int mh [3];
        int mf [3];
        int w;
        int start;
        logic [8:0] e;
        for (int i = 0; i < 3; i++) begin
            mh[i] = head[i];
            mf[i] = frames[i];
            exp_bytes[i] = 0;
        end
        while (mf[0] + mf[1] + mf[2] > 0) begin
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
            start = 0;
`else
            start = m_ptr;
`endif
            w = -1;
            for (int k = 0; k < 3; k++) begin
                if (w < 0 && mf[(start + k) % 3] > 0) w = (start + k) % 3;
            end
            m_ptr = (w + 1) % 3;
            do begin
                e = mem[w][mh[w]];
                exp_q.push_back({2'(w), e[8], e[7:0]});
                mh[w] = (mh[w] + 1) % DEPTH;
                exp_bytes[w]++;
            end while (!e[8]);
            mf[w]--;
        end
    endtask

    task automatic begin_batch();
        @(posedge clk125);
        #1;
        tx_ready  = 1'b1;
        gap_armed = 1'b0;
        for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < 3000) begin
            @(negedge clk125);
            c++;
        end
        check("drain_in_time", (c < 3000), 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pop_count_q%0d", i), rd_cnt[i], exp_bytes[i]);
        end
    endtask

    task automatic wait_accepts(input int n);
        int target;
        int c;
        target = acc_cnt + n;
        c = 0;
        while (acc_cnt < target && c < 500) begin
            @(negedge clk125);
            c++;
        end
        check("accepts_in_time", (c < 500), 1);
    endtask

    // Queue pop model: q_rd seen mid-cycle is applied just after the edge.
    initial begin : pop_proc
        logic [2:0] rd_s;
        forever begin
            @(negedge clk125);
            rd_s = q_rd;
            @(posedge clk125);
            #1;
            if (!reset) begin
                for (int i = 0; i < 3; i++) begin
                    if (rd_s[i]) begin
                        check($sformatf("pop_nonempty_q%0d", i), (head[i] != tail[i]), 1);
                        if (head[i] != tail[i]) begin
                            if (mem[i][head[i]][8]) frames[i]--;
                            head[i] = (head[i] + 1) % DEPTH;
                            rd_cnt[i]++;
                        end
                    end
                end
            end
        end
    end

    // Random MAC back-pressure.
    initial begin : ready_proc
        forever begin
            @(posedge clk125);
            #1;
            if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk125) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (q_rd != 3'b000) begin
                logic [2:0] exp_rd;
                exp_rd = 3'b001 << grant_id;
                check("q_rd_to_owner", {29'd0, q_rd}, {29'd0, exp_rd});
            end
            if (hold_pend) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, hold_data);
                check("hold_eof", tx_eof, hold_eof);
            end
            if (tx_valid) begin
                if (gap_armed) begin
                    check("ifg_gap", gap_cnt, IFG + 2);
                    gap_armed = 1'b0;
                end
                if (tx_ready) begin
                    acc_cnt++;
                    check("beat_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        beat_t b;
                        b = exp_q.pop_front();
                        check("beat_data", tx_data, b.data);
                        check("beat_eof", tx_eof, b.eof);
                        check("beat_grant", grant_id, b.gid);
                    end
                    if (tx_eof) begin
                        gap_armed = 1'b1;
                        gap_cnt   = 0;
                    end
                end
            end else if (gap_armed) begin
                gap_cnt++;
            end
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
            hold_eof  = tx_eof;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset    = 1'b1;
        tx_ready = 1'b1;
        rdy_mask = 3'b111;
        rdy_rand = 1'b0;
        m_ptr    = 0;
        acc_cnt  = 0;
        n_tests  = 0;
        n_fail   = 0;
        for (int i = 0; i < 3; i++) begin
            head[i] = 0;
            tail[i] = 0;
            frames[i] = 0;
            for (int d = 0; d < DEPTH; d++) mem[i][d] = '0;
        end

        // Reset values.
        repeat (3) @(negedge clk125);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_eof", tx_eof, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_q_rd", q_rd, 0);
        check("rst_grant", grant_id, 3);
        check("rst_busy", busy, 0);
        #1 reset = 1'b0;
        @(negedge clk125);
        check("idle_grant", grant_id, 3);
        check("idle_busy", busy, 0);

        // All queues ready, 3-byte frames: order 0,1,2,0 with fixed gaps.
        begin_batch();
        load_frame(0, 3, 8'h10, 0);
        load_frame(0, 3, 8'h40, 0);
        load_frame(1, 3, 8'h20, 0);
        load_frame(2, 3, 8'h30, 0);
        model_run();
        drain();

        // Stall after the first byte of queue 1's frame.
        begin_batch();
        tx_ready = 1'b0;
        load_frame(1, 3, 8'hA1, 0);
        model_run();
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk125);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            check("stall_data_a1", tx_data, 8'hA1);
            check("stall_valid", tx_valid, 1);
            if (k < 3) @(negedge clk125);
        end
        @(posedge clk125);
        #1 tx_ready = 1'b1;
        drain();

        // Single-byte frame on queue 2.
        begin_batch();
        load_frame(2, 1, 8'h55, 0);
        model_run();
        drain();

        // Queue 0 drops q_frame_rdy mid-frame: grant must be held.
        begin_batch();
        load_frame(0, 6, 8'h60, 0);
        model_run();
        wait_accepts(1);
        @(posedge clk125);
        #1 rdy_mask[0] = 1'b0;
        @(negedge clk125);
        check("held_grant_q0", grant_id, 0);
        check("held_busy", busy, 1);
        drain();
        rdy_mask = 3'b111;

        // Randomized batches under random back-pressure.
        for (int b = 0; b < 6; b++) begin
            begin_batch();
            n = 0;
            for (int qi = 0; qi < 3; qi++) begin
                int nf;
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) begin
                    load_frame(qi, $urandom_range(1, 6), 8'h00, 1);
                    n++;
                end
            end
            if (n == 0) load_frame($urandom_range(0, 2), $urandom_range(1, 6), 8'h00, 1);
            rdy_rand = 1'b1;
            model_run();
            drain();
            rdy_rand = 1'b0;
        end

        // Reset after the 2nd byte of a 10-byte frame.
        begin_batch();
        load_frame(0, 10, 8'hC0, 0);
        model_run();
        wait_accepts(2);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_eof", tx_eof, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_q_rd", q_rd, 0);
        check("midrst_grant", grant_id, 3);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            head[i] = tail[i];
            frames[i] = 0;
        end
        m_ptr     = 0;
        gap_armed = 1'b0;
        @(negedge clk125);
        @(negedge clk125);
        #1 reset = 1'b0;

        // Recovery after reset: pointer restarts at queue 0.
        begin_batch();
        load_frame(1, 2, 8'hD0, 0);
        load_frame(2, 1, 8'hE0, 0);
        model_run();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
